// File: rtl/tdet_pkg.sv
// Shared definitions for the trojan-detection subcircuit test sequencers.
//   state_t       : sequencer FSM states
//   DEF_*         : default parameter values for a 4-input / 1-output benchmark subcircuit
//   LFSR_TAP_*    : feedback taps of the 4-bit pattern LFSR (x^4 + x^3 + 1)
package tdet_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      APPLY   = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int unsigned DEF_PAT_W    = 4;
   localparam int unsigned DEF_LAT      = 2;
   localparam int unsigned DEF_CNT_W    = 10;
   localparam int unsigned DEF_SIG_W    = 16;
   localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
   localparam logic [3:0]  DEF_PAT_SEED = 4'b0001;

   localparam int unsigned LFSR_TAP_HI  = 3;
   localparam int unsigned LFSR_TAP_LO  = 2;

endpackage

// File: rtl/tdet_misr.sv
// Serial-input Galois MISR used to compact captured subcircuit responses.
//   clk, rst : clock, asynchronous active-high reset (signature -> 0)
//   en       : shift one response bit into the signature
//   clr      : synchronous clear to 0 (wins over en)
//   din      : serial response bit
//   sig      : current signature
//   sig_nxt  : signature value after an enabled shift of din
module tdet_misr
   import tdet_pkg::*;
#(
   parameter int unsigned      SIG_W    = DEF_SIG_W,
   parameter logic [SIG_W-1:0] SIG_POLY = DEF_SIG_POLY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             din,
   output logic [SIG_W-1:0] sig,
   output logic [SIG_W-1:0] sig_nxt
);

   always_comb begin
      sig_nxt = {sig[SIG_W-2:0], 1'b0}
              ^ (sig[SIG_W-1] ? SIG_POLY : '0)
              ^ {{(SIG_W-1){1'b0}}, din};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sig <= '0;
      else if (clr)
         sig <= '0;
      else if (en)
         sig <= sig_nxt;
   end

endmodule

// File: rtl/tdet_subckt_test_sequencer.sv
// Runs one pseudo-random test session on a benchmark subcircuit: applies LFSR
// patterns, waits out the subcircuit latency, compacts each response into a
// MISR signature and compares the final signature with a golden value.
//   I1470_clk  : clock, rising edge
//   I1477_rst  : asynchronous active-high reset
//   start      : begin a session (accepted in IDLE/DONE only)
//   pat_count  : number of patterns, latched with start
//   golden_sig : expected signature, latched with start
//   dut_out    : subcircuit output
//   dut_in     : pattern driven to the subcircuit inputs
//   busy       : session in progress
//   done       : session finished, held until the next accepted start
//   pass       : final signature matched golden (valid while done)
//   signature  : running / final MISR value
module tdet_subckt_test_sequencer
   import tdet_pkg::*;
#(
   parameter int unsigned      PAT_W    = DEF_PAT_W,
   parameter int unsigned      LAT      = DEF_LAT,
   parameter int unsigned      CNT_W    = DEF_CNT_W,
   parameter int unsigned      SIG_W    = DEF_SIG_W,
   parameter logic [SIG_W-1:0] SIG_POLY = DEF_SIG_POLY,
   parameter logic [PAT_W-1:0] PAT_SEED = DEF_PAT_SEED
) (
   input  logic             I1470_clk,
   input  logic             I1477_rst,
   input  logic             start,
   input  logic [CNT_W-1:0] pat_count,
   input  logic [SIG_W-1:0] golden_sig,
   input  logic             dut_out,
   output logic [PAT_W-1:0] dut_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature
);

   localparam int unsigned WW = (LAT > 1) ? $clog2(LAT) : 1;

   state_t           state;
   logic [PAT_W-1:0] lfsr;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] pcount_q;
   logic [SIG_W-1:0] golden_q;
   logic [SIG_W-1:0] sig_nxt;
   logic [WW-1:0]    wcnt;
   logic             accept;

   always_comb begin
      accept  = start && ((state == IDLE) || (state == DONE));
      busy    = (state == APPLY) || (state == WAIT) || (state == CAPTURE);
      done    = (state == DONE);
      cnt_inc = cnt + CNT_W'(1);
   end

   tdet_misr #(
      .SIG_W    (SIG_W),
      .SIG_POLY (SIG_POLY)
   ) u_misr (
      .clk     (I1470_clk),
      .rst     (I1477_rst),
      .en      (state == CAPTURE),
      .clr     (accept),
      .din     (dut_out),
      .sig     (signature),
      .sig_nxt (sig_nxt)
   );

   always_ff @(posedge I1470_clk or posedge I1477_rst) begin
      if (I1477_rst) begin
         state    <= IDLE;
         dut_in   <= '0;
         pass     <= 1'b0;
         lfsr     <= PAT_SEED;
         cnt      <= '0;
         pcount_q <= '0;
         golden_q <= '0;
         wcnt     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  pcount_q <= pat_count;
                  golden_q <= golden_sig;
                  lfsr     <= PAT_SEED;
                  cnt      <= '0;
                  dut_in   <= '0;
                  // An empty session finishes immediately with the cleared signature.
                  pass     <= (pat_count == '0) && (golden_sig == '0);
                  state    <= (pat_count == '0) ? DONE : APPLY;
               end
            end
            APPLY: begin
               dut_in <= lfsr;
               wcnt   <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               if (wcnt == WW'(LAT - 1))
                  state <= CAPTURE;
               else
                  wcnt <= wcnt + WW'(1);
            end
            CAPTURE: begin
               lfsr <= {lfsr[PAT_W-2:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};
               cnt  <= cnt_inc;
               if (cnt_inc == pcount_q) begin
                  // Compare against the value the MISR takes at this same edge.
                  pass   <= (sig_nxt == golden_q);
                  dut_in <= '0;
                  state  <= DONE;
               end else begin
                  state <= APPLY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tdet_subckt_test_sequencer.sv
module tb_tdet_subckt_test_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  pat_count = '0;
   logic [15:0] golden_sig = '0;
   logic        dut_out;
   logic [3:0]  dut_in;
   logic        busy, done, pass;
   logic [15:0] signature;

   int checks = 0;
   int errors = 0;
   int mode = 0;   // 0: stuck 0, 1: stuck 1, 2: parity of 2-stage DFF chain

   logic [3:0] r1, r2;

   logic       busy_log [0:99];
   logic       done_log [0:99];
   logic [3:0] din_log  [0:99];
   int busy_cnt, done_first;

   logic [3:0] seq_exp [0:15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                                  4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8, 4'd1};

   always #5 clk = ~clk;

   tdet_subckt_test_sequencer #(
      .PAT_W    (4),
      .LAT      (2),
      .CNT_W    (10),
      .SIG_W    (16),
      .SIG_POLY (16'h1021),
      .PAT_SEED (4'b0001)
   ) dut (
      .I1470_clk  (clk),
      .I1477_rst  (rst),
      .start      (start),
      .pat_count  (pat_count),
      .golden_sig (golden_sig),
      .dut_out    (dut_out),
      .dut_in     (dut_in),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .signature  (signature)
   );

   // Subcircuit stand-in: two flop stages from dut_in to dut_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1 <= '0;
         r2 <= '0;
      end else begin
         r1 <= dut_in;
         r2 <= r1;
      end
   end

   always_comb begin
      case (mode)
         0:       dut_out = 1'b0;
         1:       dut_out = 1'b1;
         default: dut_out = ^r2;
      endcase
   end

   // Starts a session and logs outputs at the negedge of each following cycle.
   // Cycle 1 is the cycle right after the edge that accepts start.
   task automatic run(input logic [9:0] pc, input logic [15:0] gold, input int ncyc);
      @(negedge clk);
      start = 1'b1; pat_count = pc; golden_sig = gold;
      busy_cnt = 0; done_first = 0;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         busy_log[k] = busy; done_log[k] = done; din_log[k] = dut_in;
         if (busy) busy_cnt++;
         if (done && done_first == 0) done_first = k;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, pass, dut_in, signature} !== 23'd0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b pass=%b dut_in=%h sig=%h expected all 0",
                  busy, done, pass, dut_in, signature);
      end
      rst = 1'b0;
   endtask

   task automatic test_sequence();
      mode = 2;
      run(10'd4, 16'h000E, 20);
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (din_log[2 + 4*j] !== seq_exp[j]) begin
            errors++;
            $display("FAIL seq_dut_in[%0d]: got %0d expected %0d", j, din_log[2 + 4*j], seq_exp[j]);
         end
      end
      checks++;
      if (busy_cnt !== 16) begin
         errors++;
         $display("FAIL seq_busy_cycles: got %0d expected 16", busy_cnt);
      end
      checks++;
      if (done_first !== 17) begin
         errors++;
         $display("FAIL seq_done_cycle: got %0d expected 17", done_first);
      end
      checks++;
      if (signature !== 16'h000E || pass !== 1'b1 || dut_in !== 4'd0) begin
         errors++;
         $display("FAIL seq_final: got sig=%h pass=%b dut_in=%h expected sig=000e pass=1 dut_in=0",
                  signature, pass, dut_in);
      end
   endtask

   task automatic test_reset_mid();
      mode = 1;
      @(negedge clk);
      start = 1'b1; pat_count = 10'd5; golden_sig = 16'h001F;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);   // cycle 3: in WAIT
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, pass, dut_in, signature} !== 23'd0) begin
         errors++;
         $display("FAIL midreset_outputs: got busy=%b done=%b pass=%b dut_in=%h sig=%h expected all 0",
                  busy, done, pass, dut_in, signature);
      end
      @(posedge clk); #1;
      checks++;
      if ({busy, done, pass, dut_in, signature} !== 23'd0) begin
         errors++;
         $display("FAIL midreset_hold: got busy=%b done=%b pass=%b dut_in=%h sig=%h expected all 0",
                  busy, done, pass, dut_in, signature);
      end
      @(negedge clk);
      rst = 1'b0;
      run(10'd5, 16'h001F, 25);
      checks++;
      if (din_log[2] !== 4'd1) begin
         errors++;
         $display("FAIL midreset_first_pattern: got %0d expected 1", din_log[2]);
      end
      checks++;
      if (busy_cnt !== 20 || done_first !== 21) begin
         errors++;
         $display("FAIL midreset_session: got busy=%0d done_cycle=%0d expected 20 21", busy_cnt, done_first);
      end
      checks++;
      if (signature !== 16'h001F || pass !== 1'b1) begin
         errors++;
         $display("FAIL midreset_sig: got sig=%h pass=%b expected 001f 1", signature, pass);
      end
   endtask

   task automatic test_stuck0();
      mode = 0;
      run(10'd7, 16'h0000, 35);
      checks++;
      if (done_first !== 29) begin
         errors++;
         $display("FAIL stuck0_done_cycle: got %0d expected 29", done_first);
      end
      checks++;
      if (signature !== 16'h0000 || done !== 1'b1 || pass !== 1'b1) begin
         errors++;
         $display("FAIL stuck0_result: got sig=%h done=%b pass=%b expected 0000 1 1", signature, done, pass);
      end
   endtask

   task automatic test_stuck1();
      mode = 1;
      run(10'd1, 16'h0001, 8);
      checks++;
      if (signature !== 16'h0001 || pass !== 1'b1 || done !== 1'b1) begin
         errors++;
         $display("FAIL stuck1_pc1: got sig=%h pass=%b done=%b expected 0001 1 1", signature, pass, done);
      end
      run(10'd2, 16'h0002, 12);
      checks++;
      if (signature !== 16'h0003 || pass !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL stuck1_pc2: got sig=%h pass=%b done=%b expected 0003 0 1", signature, pass, done);
      end
   endtask

   task automatic test_zero();
      mode = 1;
      run(10'd0, 16'h0000, 5);
      checks++;
      if (busy_cnt !== 0) begin
         errors++;
         $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_cnt);
      end
      checks++;
      if (done_log[1] !== 1'b1 || signature !== 16'h0000 || pass !== 1'b1) begin
         errors++;
         $display("FAIL zero_result: got done=%b sig=%h pass=%b expected 1 0000 1",
                  done_log[1], signature, pass);
      end
   endtask

   task automatic test_wrap();
      mode = 0;
      run(10'd16, 16'h0000, 70);
      for (int j = 0; j < 16; j++) begin
         checks++;
         if (din_log[2 + 4*j] !== seq_exp[j]) begin
            errors++;
            $display("FAIL wrap_dut_in[%0d]: got %0d expected %0d", j, din_log[2 + 4*j], seq_exp[j]);
         end
      end
      checks++;
      if (done_first !== 65) begin
         errors++;
         $display("FAIL wrap_done_cycle: got %0d expected 65", done_first);
      end
   endtask

   task automatic test_busy_ignore();
      mode = 1;
      @(negedge clk);
      start = 1'b1; pat_count = 10'd3; golden_sig = 16'h0007;
      busy_cnt = 0; done_first = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 5) begin
            start = 1'b1; pat_count = 10'd1; golden_sig = 16'h0000;
         end
         if (k == 6) start = 1'b0;
         if (busy) busy_cnt++;
         if (done && done_first == 0) done_first = k;
      end
      checks++;
      if (busy_cnt !== 12 || done_first !== 13) begin
         errors++;
         $display("FAIL ignore_session: got busy=%0d done_cycle=%0d expected 12 13", busy_cnt, done_first);
      end
      checks++;
      if (signature !== 16'h0007 || pass !== 1'b1) begin
         errors++;
         $display("FAIL ignore_result: got sig=%h pass=%b expected 0007 1", signature, pass);
      end
   endtask

   task automatic test_held_start();
      mode = 1;
      @(negedge clk);
      start = 1'b1; pat_count = 10'd2; golden_sig = 16'h0003;
      done_first = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL held_restart: got done=%b busy=%b expected 0 1", done, busy);
            end
         end
         if (k == 3) start = 1'b0;
         if (done && done_first == 0) done_first = k;
      end
      checks++;
      if (done_first !== 9 || signature !== 16'h0003 || pass !== 1'b1) begin
         errors++;
         $display("FAIL held_result: got done_cycle=%0d sig=%h pass=%b expected 9 0003 1",
                  done_first, signature, pass);
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_reset_mid();
      test_stuck0();
      test_stuck1();
      test_zero();
      test_wrap();
      test_busy_ignore();
      test_held_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
